// File: rtl/otter_mem_arbiter.sv
// Two-master arbiter for OTTER memory port 2: CPU load/store (M0) and DMA/debug loader (M1).
// Define OTTER_ARB_RR_EN for round-robin conflict resolution in IDLE; default is fixed M0 priority.
module otter_mem_arbiter #(
  parameter int BURST_MAX = 8,
  parameter int CNT_W     = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        M0_REQ,
  input  logic        M0_WE,
  input  logic        M0_LOCK,
  input  logic [31:0] M0_ADDR,
  input  logic [31:0] M0_DIN,
  input  logic [1:0]  M0_SIZE,
  input  logic        M0_SIGN,
  output logic        M0_GNT,
  output logic        M0_RVALID,
  output logic [31:0] M0_DOUT,
  input  logic        M1_REQ,
  input  logic        M1_WE,
  input  logic        M1_LOCK,
  input  logic [31:0] M1_ADDR,
  input  logic [31:0] M1_DIN,
  input  logic [1:0]  M1_SIZE,
  input  logic        M1_SIGN,
  output logic        M1_GNT,
  output logic        M1_RVALID,
  output logic [31:0] M1_DOUT,
  output logic [31:0] MEM_ADDR2,
  output logic [31:0] MEM_DIN2,
  output logic        MEM_WRITE2,
  output logic        MEM_READ2,
  output logic [1:0]  MEM_SIZE,
  output logic        MEM_SIGN,
  input  logic [31:0] MEM_DOUT2
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic             gnt0, gnt1, forced;
  logic             rd_pend_p1, rd_own_p1;
`ifdef OTTER_ARB_RR_EN
  logic             rr_last_q;
`endif

  // State register and read-return stage
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      bcnt_q     <= '0;
      rd_pend_p1 <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      rd_pend_p1 <= (gnt0 && !M0_WE) || (gnt1 && !M1_WE);
    end
  end

  always_ff @(posedge CLK) begin
    if (gnt0 || gnt1) rd_own_p1 <= gnt1;
  end

`ifdef OTTER_ARB_RR_EN
  // Pointer records the last granted master; reset value 1 lets M0 win the first conflict.
  always_ff @(posedge CLK) begin
    if (RST)
      rr_last_q <= 1'b1;
    else if (gnt0 || gnt1)
      rr_last_q <= gnt1;
  end
`endif

  // Grant decision: owner priority, forced hand-off once the burst limit is reached
  always_comb begin
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    forced = 1'b0;
    case (state_q)
      IDLE: begin
        if (M0_REQ && M1_REQ) begin
`ifdef OTTER_ARB_RR_EN
          gnt0 = rr_last_q;
          gnt1 = !rr_last_q;
`else
          gnt0 = 1'b1;
`endif
        end else begin
          gnt0 = M0_REQ;
          gnt1 = M1_REQ;
        end
      end
      OWN0: begin
        if (bcnt_q == BURST_LIM && M1_REQ) begin
          gnt1   = 1'b1;
          forced = 1'b1;
        end else if (M0_REQ) begin
          gnt0 = 1'b1;
        end else begin
          gnt1 = M1_REQ;
        end
      end
      OWN1: begin
        if (bcnt_q == BURST_LIM && M0_REQ) begin
          gnt0   = 1'b1;
          forced = 1'b1;
        end else if (M1_REQ) begin
          gnt1 = 1'b1;
        end else begin
          gnt0 = M0_REQ;
        end
      end
      default: begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
      end
    endcase
    if (RST) begin
      gnt0   = 1'b0;
      gnt1   = 1'b0;
      forced = 1'b0;
    end
  end

  // Next state and burst counter
  always_comb begin
    logic owner_gnt;
    logic other_req;
    state_d   = state_q;
    owner_gnt = 1'b0;
    other_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt0 && M0_LOCK)      state_d = OWN0;
        else if (gnt1 && M1_LOCK) state_d = OWN1;
      end
      OWN0: begin
        owner_gnt = gnt0;
        other_req = M1_REQ;
        if (forced || (gnt0 && !M0_LOCK) || (gnt1 && !M0_REQ)) state_d = IDLE;
      end
      OWN1: begin
        owner_gnt = gnt1;
        other_req = M0_REQ;
        if (forced || (gnt1 && !M1_LOCK) || (gnt0 && !M1_REQ)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q || !other_req)
      bcnt_d = '0;
    else if (owner_gnt)
      bcnt_d = bcnt_q + CNT_W'(1);
    else
      bcnt_d = bcnt_q;
  end

  // Memory drive from the granted master
  always_comb begin
    MEM_ADDR2  = '0;
    MEM_DIN2   = '0;
    MEM_WRITE2 = 1'b0;
    MEM_READ2  = 1'b0;
    MEM_SIZE   = '0;
    MEM_SIGN   = 1'b0;
    if (gnt0) begin
      MEM_ADDR2  = M0_ADDR;
      MEM_DIN2   = M0_DIN;
      MEM_WRITE2 = M0_WE;
      MEM_READ2  = !M0_WE;
      MEM_SIZE   = M0_SIZE;
      MEM_SIGN   = M0_SIGN;
    end else if (gnt1) begin
      MEM_ADDR2  = M1_ADDR;
      MEM_DIN2   = M1_DIN;
      MEM_WRITE2 = M1_WE;
      MEM_READ2  = !M1_WE;
      MEM_SIZE   = M1_SIZE;
      MEM_SIGN   = M1_SIGN;
    end
  end

  // Response routing; a reset in the return cycle drops the response
  always_comb begin
    M0_GNT    = gnt0;
    M1_GNT    = gnt1;
    M0_RVALID = rd_pend_p1 && !rd_own_p1 && !RST;
    M1_RVALID = rd_pend_p1 && rd_own_p1 && !RST;
    M0_DOUT   = M0_RVALID ? MEM_DOUT2 : 32'h0;
    M1_DOUT   = M1_RVALID ? MEM_DOUT2 : 32'h0;
  end

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Directed bench for otter_mem_arbiter with a word-wide memory model behind port 2.
module tb_otter_mem_arbiter;

  logic        CLK = 1'b0, RST;
  logic        M0_REQ, M0_WE, M0_LOCK, M0_SIGN, M1_REQ, M1_WE, M1_LOCK, M1_SIGN;
  logic [31:0] M0_ADDR, M0_DIN, M1_ADDR, M1_DIN;
  logic [1:0]  M0_SIZE, M1_SIZE;
  logic        M0_GNT, M0_RVALID, M1_GNT, M1_RVALID;
  logic [31:0] M0_DOUT, M1_DOUT;
  logic [31:0] MEM_ADDR2, MEM_DIN2, MEM_DOUT2;
  logic        MEM_WRITE2, MEM_READ2, MEM_SIGN;
  logic [1:0]  MEM_SIZE;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [0:1023];

  always #5 CLK = ~CLK;

  otter_mem_arbiter #(.BURST_MAX(4), .CNT_W(3)) dut (
    .CLK(CLK), .RST(RST),
    .M0_REQ(M0_REQ), .M0_WE(M0_WE), .M0_LOCK(M0_LOCK), .M0_ADDR(M0_ADDR),
    .M0_DIN(M0_DIN), .M0_SIZE(M0_SIZE), .M0_SIGN(M0_SIGN),
    .M0_GNT(M0_GNT), .M0_RVALID(M0_RVALID), .M0_DOUT(M0_DOUT),
    .M1_REQ(M1_REQ), .M1_WE(M1_WE), .M1_LOCK(M1_LOCK), .M1_ADDR(M1_ADDR),
    .M1_DIN(M1_DIN), .M1_SIZE(M1_SIZE), .M1_SIGN(M1_SIGN),
    .M1_GNT(M1_GNT), .M1_RVALID(M1_RVALID), .M1_DOUT(M1_DOUT),
    .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2), .MEM_WRITE2(MEM_WRITE2),
    .MEM_READ2(MEM_READ2), .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN),
    .MEM_DOUT2(MEM_DOUT2)
  );

  // Memory model: word array preloaded with 0xC0DE0000 | word index, IO range not stored
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE0000 | 32'(i);
  end

  always @(posedge CLK) begin
    if (MEM_WRITE2 && MEM_ADDR2 < 32'h11000000) mem[MEM_ADDR2[11:2]] <= MEM_DIN2;
    if (MEM_READ2) MEM_DOUT2 <= mem[MEM_ADDR2[11:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_all();
    M0_REQ = 0; M0_WE = 0; M0_LOCK = 0; M0_ADDR = 0; M0_DIN = 0; M0_SIZE = 0; M0_SIGN = 0;
    M1_REQ = 0; M1_WE = 0; M1_LOCK = 0; M1_ADDR = 0; M1_DIN = 0; M1_SIZE = 0; M1_SIGN = 0;
  endtask

  task automatic m0_rd(input logic [31:0] a, input logic lk);
    M0_REQ = 1; M0_WE = 0; M0_LOCK = lk; M0_ADDR = a; M0_SIZE = 2'd2;
  endtask

  task automatic m1_rd(input logic [31:0] a, input logic lk);
    M1_REQ = 1; M1_WE = 0; M1_LOCK = lk; M1_ADDR = a; M1_SIZE = 2'd2;
  endtask

  initial begin
    logic exp_g0;
    logic prev_g0;
    MEM_DOUT2 = 32'h0;
    idle_all();
    RST = 1;
    m0_rd(32'h100, 1'b0);
    cyc();
    @(negedge CLK);
    chk("rst_gnt0", {31'b0, M0_GNT}, 32'd0);
    chk("rst_gnt1", {31'b0, M1_GNT}, 32'd0);
    chk("rst_read", {31'b0, MEM_READ2}, 32'd0);
    chk("rst_addr", MEM_ADDR2, 32'h0);
    chk("rst_rvalid0", {31'b0, M0_RVALID}, 32'd0);
    chk("rst_dout0", M0_DOUT, 32'h0);

    // Single read
    cyc();
    RST = 0;
    @(negedge CLK);
    chk("rd_gnt0", {31'b0, M0_GNT}, 32'd1);
    chk("rd_gnt1", {31'b0, M1_GNT}, 32'd0);
    chk("rd_read", {31'b0, MEM_READ2}, 32'd1);
    chk("rd_write", {31'b0, MEM_WRITE2}, 32'd0);
    chk("rd_addr", MEM_ADDR2, 32'h100);
    chk("rd_size", {30'b0, MEM_SIZE}, 32'd2);
    cyc();
    idle_all();
    @(negedge CLK);
    chk("rd_rvalid0", {31'b0, M0_RVALID}, 32'd1);
    chk("rd_dout0", M0_DOUT, 32'hC0DE0040);
    chk("rd_rvalid1", {31'b0, M1_RVALID}, 32'd0);
    chk("rd_dout1", M1_DOUT, 32'h0);
    chk("idle_read", {31'b0, MEM_READ2}, 32'd0);

    // Write then read from the other master
    cyc();
    M0_REQ = 1; M0_WE = 1; M0_ADDR = 32'h200; M0_DIN = 32'hDEADBEEF; M0_SIZE = 2'd2;
    @(negedge CLK);
    chk("wr_write", {31'b0, MEM_WRITE2}, 32'd1);
    chk("wr_read", {31'b0, MEM_READ2}, 32'd0);
    chk("wr_din", MEM_DIN2, 32'hDEADBEEF);
    cyc();
    idle_all();
    m1_rd(32'h200, 1'b0);
    @(negedge CLK);
    chk("wr_rd_gnt1", {31'b0, M1_GNT}, 32'd1);
    chk("wr_no_rvalid0", {31'b0, M0_RVALID}, 32'd0);
    cyc();
    idle_all();
    @(negedge CLK);
    chk("wr_rd_rvalid1", {31'b0, M1_RVALID}, 32'd1);
    chk("wr_rd_dout1", M1_DOUT, 32'hDEADBEEF);
    chk("wr_rd_dout0", M0_DOUT, 32'h0);

    // Conflict without lock; last grant was M1, so round-robin starts with M0
    prev_g0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      m0_rd(32'h104, 1'b0);
      m1_rd(32'h108, 1'b0);
      @(negedge CLK);
`ifdef OTTER_ARB_RR_EN
      exp_g0 = (i % 2 == 0);
`else
      exp_g0 = 1'b1;
`endif
      chk($sformatf("cf_gnt0_%0d", i), {31'b0, M0_GNT}, {31'b0, exp_g0});
      chk($sformatf("cf_gnt1_%0d", i), {31'b0, M1_GNT}, {31'b0, !exp_g0});
      if (i > 0) begin
        chk($sformatf("cf_rv0_%0d", i), {31'b0, M0_RVALID}, {31'b0, prev_g0});
        chk($sformatf("cf_dout_%0d", i), prev_g0 ? M0_DOUT : M1_DOUT,
            prev_g0 ? 32'hC0DE0041 : 32'hC0DE0042);
      end
      prev_g0 = exp_g0;
    end

    // Lock with forced hand-off after 4 contended grants
    cyc();
    idle_all();
    m1_rd(32'h300, 1'b1);
    @(negedge CLK);
    chk("lk_enter_gnt1", {31'b0, M1_GNT}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      cyc();
      m0_rd(32'h104, 1'b0);
      @(negedge CLK);
      chk($sformatf("lk_burst_gnt1_%0d", k), {31'b0, M1_GNT}, 32'd1);
      chk($sformatf("lk_burst_gnt0_%0d", k), {31'b0, M0_GNT}, 32'd0);
    end
    cyc();
    @(negedge CLK);
    chk("lk_hand_gnt0", {31'b0, M0_GNT}, 32'd1);
    chk("lk_hand_gnt1", {31'b0, M1_GNT}, 32'd0);
    cyc();
    M0_REQ = 0;
    @(negedge CLK);
    chk("lk_again_gnt1", {31'b0, M1_GNT}, 32'd1);
    cyc();
    m0_rd(32'h104, 1'b0);
    @(negedge CLK);
    chk("lk_owner_gnt1", {31'b0, M1_GNT}, 32'd1);
    chk("lk_owner_gnt0", {31'b0, M0_GNT}, 32'd0);
    cyc();
    M1_LOCK = 0;
    @(negedge CLK);
    chk("lk_release_gnt1", {31'b0, M1_GNT}, 32'd1);
    cyc();
    @(negedge CLK);
    chk("lk_idle_gnt0", {31'b0, M0_GNT}, 32'd1);
    chk("lk_idle_gnt1", {31'b0, M1_GNT}, 32'd0);

    // Reset on the cycle after a granted locking read
    cyc();
    idle_all();
    m1_rd(32'h100, 1'b1);
    @(negedge CLK);
    chk("rr_gnt1", {31'b0, M1_GNT}, 32'd1);
    cyc();
    idle_all();
    RST = 1;
    @(negedge CLK);
    chk("rr_rvalid1", {31'b0, M1_RVALID}, 32'd0);
    chk("rr_dout1", M1_DOUT, 32'h0);
    cyc();
    RST = 0;
    m0_rd(32'h104, 1'b0);
    m1_rd(32'h108, 1'b0);
    @(negedge CLK);
    chk("rr_post_rvalid1", {31'b0, M1_RVALID}, 32'd0);
    chk("rr_post_gnt0", {31'b0, M0_GNT}, 32'd1);
    chk("rr_post_gnt1", {31'b0, M1_GNT}, 32'd0);

    // IO-range write passes through
    cyc();
    idle_all();
    M1_REQ = 1; M1_WE = 1; M1_ADDR = 32'h11000000; M1_DIN = 32'h12345678; M1_SIZE = 2'd2;
    @(negedge CLK);
    chk("io_write", {31'b0, MEM_WRITE2}, 32'd1);
    chk("io_addr", MEM_ADDR2, 32'h11000000);
    chk("io_din", MEM_DIN2, 32'h12345678);
    chk("io_read", {31'b0, MEM_READ2}, 32'd0);
    cyc();
    idle_all();
    @(negedge CLK);
    chk("io_no_rvalid1", {31'b0, M1_RVALID}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
